// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles every non-clock signal of the two-requester ALU arbiter.
//   req0_* / req1_* : requester valid/ready handshake plus ctrl (5b) and operands a/b (32b)
//   alu_*           : operation driven to the shared ALU and its combinational results
//   rsp_*           : registered response with valid/ready handshake and owner id
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding system (requesters, ALU and response consumer)
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_ctrl;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_ctrl;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic [4:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic [31:0] alu_out_high;
  logic        alu_zero;
  logic        alu_overflow;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_out;
  logic [31:0] rsp_high;
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_illegal;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_ctrl, alu_a, alu_b,
    input  alu_out, alu_out_high, alu_zero, alu_overflow,
    output rsp_valid, rsp_id, rsp_out, rsp_high, rsp_zero, rsp_ovf, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_ctrl, alu_a, alu_b,
    output alu_out, alu_out_high, alu_zero, alu_overflow,
    input  rsp_valid, rsp_id, rsp_out, rsp_high, rsp_zero, rsp_ovf, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters, one operation in flight.
// Each operation passes IDLE (grant) -> EXEC (ALU evaluates latched operands)
// -> RESP (registered result held until consumed).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_arbiter_if.slave carrying requester, ALU and response signals
// Parameter:
//   PRIO_INIT : requester that wins the first tie after reset
module alu_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [4:0] CTRL_ADD = 5'd2;
  localparam logic [4:0] CTRL_MUL = 5'd5;
  localparam logic [4:0] CTRL_SUB = 5'd6;
  localparam logic [4:0] CTRL_MAX = 5'd20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        last_grant;
  logic        grant_any;
  logic        grant_id;

  logic [4:0]  op_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_id;

  logic [31:0] rsp_out_q;
  logic [31:0] rsp_high_q;
  logic        rsp_zero_q;
  logic        rsp_ovf_q;
  logic        rsp_illegal_q;

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, grant decision and handshake outputs.
  // The grant is gated by rst_n so ready stays low while reset is held,
  // even though the FSM already sits in IDLE.
  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    state_nxt      = state;
    grant_any      = 1'b0;
    grant_id       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          grant_any = 1'b1;
          if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant;
          end else begin
            grant_id = bus.req1_valid;
          end
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          state_nxt      = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch and round-robin history, updated only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_ctrl    <= 5'd0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      op_id      <= 1'b0;
      last_grant <= ~PRIO_INIT;
    end else if (grant_any) begin
      op_id      <= grant_id;
      last_grant <= grant_id;
      if (grant_id) begin
        op_ctrl <= bus.req1_ctrl;
        op_a    <= bus.req1_a;
        op_b    <= bus.req1_b;
      end else begin
        op_ctrl <= bus.req0_ctrl;
        op_a    <= bus.req0_a;
        op_b    <= bus.req0_b;
      end
    end
  end

  // Result capture at the end of EXEC. Overflow only means something for
  // ADD/SUB and the high word only for MUL, so both are masked otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_out_q     <= 32'd0;
      rsp_high_q    <= 32'd0;
      rsp_zero_q    <= 1'b0;
      rsp_ovf_q     <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else if (state == EXEC) begin
      rsp_out_q     <= bus.alu_out;
      rsp_high_q    <= (op_ctrl == CTRL_MUL) ? bus.alu_out_high : 32'd0;
      rsp_zero_q    <= bus.alu_zero;
      rsp_ovf_q     <= ((op_ctrl == CTRL_ADD) || (op_ctrl == CTRL_SUB)) ? bus.alu_overflow : 1'b0;
      rsp_illegal_q <= (op_ctrl > CTRL_MAX);
    end
  end

  // The ALU always sees the latched operation, keeping it stable through EXEC and RESP.
  assign bus.alu_ctrl    = op_ctrl;
  assign bus.alu_a       = op_a;
  assign bus.alu_b       = op_b;

  assign bus.rsp_id      = op_id;
  assign bus.rsp_out     = rsp_out_q;
  assign bus.rsp_high    = rsp_high_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_ovf     = rsp_ovf_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, compared cycle by cycle against a transaction-level reference model.
module tb_alu_arbiter;

  localparam logic PRIO = 1'b0;

  logic clk;
  logic rst_n;

  alu_arbiter_if bus ();

  alu_arbiter #(.PRIO_INIT(PRIO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one in-flight operation with its age in cycles since grant.
  logic        m_busy;
  int          m_age;
  logic        m_last;
  logic [4:0]  m_ctrl;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_id;
  logic        seen_ids[$];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU function shared by the environment ALU and the expectation.
  function automatic logic [31:0] ref_out(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (c > 5'd20) return 32'd0;
    p = {32'd0, a} * {32'd0, b};
    case (c)
      5'd0:    return a & b;
      5'd1:    return a | b;
      5'd2:    return a + b;
      5'd3:    return a ^ b;
      5'd4:    return a << b[4:0];
      5'd5:    return p[31:0];
      5'd6:    return a - b;
      5'd7:    return ~(a | b);
      5'd8:    return {31'd0, $signed(a) < $signed(b)};
      default: return a + b + {27'd0, c};
    endcase
  endfunction

  function automatic logic [31:0] mul_high(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[63:32];
  endfunction

  function automatic logic signed_ovf(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (c == 5'd2) begin
      r = a + b;
      return (a[31] == b[31]) && (r[31] != a[31]);
    end
    if (c == 5'd6) begin
      r = a - b;
      return (a[31] != b[31]) && (r[31] != a[31]);
    end
    return 1'b0;
  endfunction

  // Environment ALU; high word and overflow carry junk outside MUL/ADD/SUB
  // so any missing masking in the arbiter becomes visible.
  always_comb begin
    bus.alu_out      = ref_out(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    bus.alu_zero     = (bus.alu_out == 32'd0);
    bus.alu_out_high = (bus.alu_ctrl == 5'd5) ? mul_high(bus.alu_a, bus.alu_b) : ~bus.alu_a;
    bus.alu_overflow = ((bus.alu_ctrl == 5'd2) || (bus.alu_ctrl == 5'd6)) ?
                       signed_ovf(bus.alu_ctrl, bus.alu_a, bus.alu_b) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_winner(input logic v0, input logic v1);
    if (v0 && v1) return ~m_last;
    return v1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_last = ~PRIO;
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [4:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic rr);
    bus.req0_valid = v0;
    bus.req0_ctrl  = c0;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req1_valid = v1;
    bus.req1_ctrl  = c1;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
    bus.rsp_ready  = rr;
    #1;
  endtask

  // Compare every observable output with what the model expects this cycle.
  task automatic checkOutput();
    logic grant;
    logic w;
    logic resp;
    grant = !m_busy && (bus.req0_valid || bus.req1_valid);
    w     = model_winner(bus.req0_valid, bus.req1_valid);
    resp  = m_busy && (m_age >= 2);
    check("req0_ready", 64'(bus.req0_ready), 64'(grant && !w));
    check("req1_ready", 64'(bus.req1_ready), 64'(grant && w));
    check("rsp_valid",  64'(bus.rsp_valid),  64'(resp));
    if (m_busy) begin
      check("alu_ctrl", 64'(bus.alu_ctrl), 64'(m_ctrl));
      check("alu_a",    64'(bus.alu_a),    64'(m_a));
      check("alu_b",    64'(bus.alu_b),    64'(m_b));
    end
    if (resp) begin
      check("rsp_id",      64'(bus.rsp_id),      64'(m_id));
      check("rsp_out",     64'(bus.rsp_out),     64'(ref_out(m_ctrl, m_a, m_b)));
      check("rsp_high",    64'(bus.rsp_high),    64'((m_ctrl == 5'd5) ? mul_high(m_a, m_b) : 32'd0));
      check("rsp_zero",    64'(bus.rsp_zero),    64'(ref_out(m_ctrl, m_a, m_b) == 32'd0));
      check("rsp_ovf",     64'(bus.rsp_ovf),     64'(signed_ovf(m_ctrl, m_a, m_b)));
      check("rsp_illegal", 64'(bus.rsp_illegal), 64'(m_ctrl > 5'd20));
    end
    if (bus.rsp_valid && bus.rsp_ready) seen_ids.push_back(bus.rsp_id);
  endtask

  // Advance the model across the coming edge, then move to 1 time unit after it.
  task automatic tick();
    logic w;
    if (m_busy) begin
      if (m_age >= 2 && bus.rsp_ready) m_busy = 1'b0;
      else m_age++;
    end else if (bus.req0_valid || bus.req1_valid) begin
      w      = model_winner(bus.req0_valid, bus.req1_valid);
      m_last = w;
      m_busy = 1'b1;
      m_age  = 1;
      m_id   = w;
      m_ctrl = w ? bus.req1_ctrl : bus.req0_ctrl;
      m_a    = w ? bus.req1_a    : bus.req0_a;
      m_b    = w ? bus.req1_b    : bus.req0_b;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v0, input logic [4:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic v1, input logic [4:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic rr);
    applyStimulus(v0, c0, a0, b0, v1, c1, a1, b1, rr);
    checkOutput();
    tick();
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    check("rst rsp_valid", 64'(bus.rsp_valid),  64'(0));
    check("rst req0_rdy",  64'(bus.req0_ready), 64'(0));
    check("rst req1_rdy",  64'(bus.req1_ready), 64'(0));
    check("rst rsp_out",   64'(bus.rsp_out),    64'(0));
    check("rst rsp_id",    64'(bus.rsp_id),     64'(0));
    check("rst alu_a",     64'(bus.alu_a),      64'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Directed scenarios, then random traffic, then the summary.
  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h1234, 32'h5678, 1'b1, 5'd1, 32'h9, 32'h7, 1'b0);
    @(posedge clk);
    #1;
    doReset();

    // req0 ADD overflow with latency check
    applyStimulus(1'b1, 5'd2, 32'h7FFFFFFF, 32'd1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    check("029 ready0", 64'(bus.req0_ready), 64'(1));
    checkOutput();
    tick();
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    check("029 rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check("029 rsp_out",   64'(bus.rsp_out),   64'(32'h80000000));
    check("029 rsp_ovf",   64'(bus.rsp_ovf),   64'(1));
    check("029 rsp_id",    64'(bus.rsp_id),    64'(0));
    checkOutput();
    tick();

    // req1 MUL producing a high word only
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 32'h10000, 32'h10000, 1'b1);
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    check("031 rsp_out",  64'(bus.rsp_out),  64'(0));
    check("031 rsp_high", 64'(bus.rsp_high), 64'(1));
    check("031 rsp_zero", 64'(bus.rsp_zero), 64'(1));
    check("031 rsp_ovf",  64'(bus.rsp_ovf),  64'(0));
    check("031 rsp_id",   64'(bus.rsp_id),   64'(1));
    checkOutput();
    tick();

    // Back-pressure: response held for 5 cycles with both requesters waiting
    step(1'b1, 5'd0, 32'hF0F0, 32'hFF00, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 5'd1, 32'h1, 32'h2, 1'b1, 5'd3, 32'h3, 32'h4, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 5'd1, 32'h1, 32'h2, 1'b1, 5'd3, 32'h3, 32'h4, 1'b0);
    step(1'b1, 5'd1, 32'h1, 32'h2, 1'b1, 5'd3, 32'h3, 32'h4, 1'b1);
    step(1'b1, 5'd1, 32'h1, 32'h2, 1'b1, 5'd3, 32'h3, 32'h4, 1'b1);
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);

    // Illegal opcode, then a legal shift
    step(1'b1, 5'd25, 32'h5, 32'h6, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    check("033 illegal", 64'(bus.rsp_illegal), 64'(1));
    check("033 rsp_out", 64'(bus.rsp_out),     64'(0));
    checkOutput();
    tick();
    step(1'b1, 5'd4, 32'h3, 32'h4, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    check("033 legal",   64'(bus.rsp_illegal), 64'(0));
    check("033 shl",     64'(bus.rsp_out),     64'(32'h30));
    checkOutput();
    tick();

    // Continuous contention from a fresh reset alternates 0,1,0,1
    doReset();
    seen_ids.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 5'd2, 32'(i), 32'd1, 1'b1, 5'd6, 32'(i), 32'd1, 1'b1);
    check("030 count", 64'(seen_ids.size()), 64'(4));
    if (seen_ids.size() == 4) begin
      check("030 id0", 64'(seen_ids[0]), 64'(0));
      check("030 id1", 64'(seen_ids[1]), 64'(1));
      check("030 id2", 64'(seen_ids[2]), 64'(0));
      check("030 id3", 64'(seen_ids[3]), 64'(1));
    end
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);

    // Reset during EXEC drops the operation; the next tie goes to PRIO
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd2, 32'h11, 32'h22, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    checkOutput();
    doReset();
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b1, 5'd3, 32'hA, 32'h5, 1'b1, 5'd3, 32'hB, 32'h5, 1'b1);
    check("034 ready0", 64'(bus.req0_ready), 64'(!PRIO));
    check("034 ready1", 64'(bus.req1_ready), 64'(PRIO));
    checkOutput();
    tick();

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 96) == 0) begin
        doReset();
      end else begin
        step(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 23)), $urandom, $urandom,
             ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 23)), $urandom, $urandom,
             ($urandom_range(0, 3) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
